// File: rtl/dcache_pkg.sv
// Shared types and address helpers for the direct-mapped write-through data cache.
package dcache_pkg;

  localparam int LINES_DEF = 16;
  localparam int IDX_W_DEF = 4;
  localparam int TAG_W_DEF = 26;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FILL  = 2'd1,
    WRITE = 2'd2,
    RESP  = 2'd3
  } state_t;

  // Word index within the cache: address bits [idx_w+1:2], zero-extended.
  function automatic logic [31:0] word_index(input logic [31:0] addr, input int idx_w);
    return (addr >> 2) & ((32'd1 << idx_w) - 32'd1);
  endfunction

  // Tag: everything above the index bits, zero-extended.
  function automatic logic [31:0] addr_tag(input logic [31:0] addr, input int idx_w);
    return addr >> (idx_w + 2);
  endfunction

endpackage

// File: rtl/dcache_array.sv
// Valid/tag/data storage: one write port, one combinational lookup port.
module dcache_array
  import dcache_pkg::*;
#(
  parameter int LINES = LINES_DEF,
  parameter int IDX_W = IDX_W_DEF,
  parameter int TAG_W = TAG_W_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr_en,
  input  logic [IDX_W-1:0] wr_idx,
  input  logic [TAG_W-1:0] wr_tag,
  input  logic [31:0]      wr_data,
  input  logic             wr_valid,
  input  logic [IDX_W-1:0] rd_idx,
  input  logic [TAG_W-1:0] rd_tag,
  output logic             rd_hit,
  output logic [31:0]      rd_data
);

  logic [LINES-1:0] valid;
  logic [TAG_W-1:0] tag_mem  [LINES];
  logic [31:0]      data_mem [LINES];

  // Only the valid bits are cleared; stale tags/data are masked by valid.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid <= '0;
    end else if (wr_en && wr_valid) begin
      valid[wr_idx] <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      tag_mem[wr_idx]  <= wr_tag;
      data_mem[wr_idx] <= wr_data;
    end
  end

  assign rd_hit  = valid[rd_idx] && (tag_mem[rd_idx] == rd_tag);
  assign rd_data = data_mem[rd_idx];

endmodule

// File: rtl/data_cache_ctrl.sv
// MEM-stage data cache controller: direct-mapped, one word per line,
// write-through, no-write-allocate, backed by a req/ack memory.
module data_cache_ctrl
  import dcache_pkg::*;
#(
  parameter int LINES = LINES_DEF,
  parameter int IDX_W = $clog2(LINES),
  parameter int TAG_W = 30 - IDX_W
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        MemRead,
  input  logic        MemWrite,
  input  logic [31:0] Address,
  input  logic [31:0] Write_Data,
  output logic [31:0] Read_data,
  output logic        Stall,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
  output logic [15:0] hit_cnt,
  output logic [15:0] miss_cnt
);

  state_t           state;
  logic [31:0]      addr_reg;
  logic [31:0]      resp_reg;
  logic [31:0]      lookup_addr;
  logic [IDX_W-1:0] lookup_idx;
  logic [TAG_W-1:0] lookup_tag;
  logic             hit;
  logic [31:0]      line_data;
  logic             wr_en;
  logic [31:0]      wr_data;
  logic             is_store;
  logic             is_load;

  // A simultaneous read+write request is handled as a store.
  assign is_store = MemWrite;
  assign is_load  = MemRead & ~MemWrite;

  // Outside IDLE the lookup uses the latched address, so the store-hit check
  // at mem_ack sees the original request and not the frozen pipeline inputs.
  assign lookup_addr = (state == IDLE) ? Address : addr_reg;
  assign lookup_idx  = IDX_W'(word_index(lookup_addr, IDX_W));
  assign lookup_tag  = TAG_W'(addr_tag(lookup_addr, IDX_W));

  assign wr_en   = mem_ack & ((state == FILL) | ((state == WRITE) & hit));
  assign wr_data = (state == FILL) ? mem_rdata : mem_wdata;

  dcache_array #(
    .LINES(LINES),
    .IDX_W(IDX_W),
    .TAG_W(TAG_W)
  ) u_array (
    .clk     (CLK),
    .rst_n   (RESET),
    .wr_en   (wr_en),
    .wr_idx  (lookup_idx),
    .wr_tag  (lookup_tag),
    .wr_data (wr_data),
    .wr_valid(1'b1),
    .rd_idx  (lookup_idx),
    .rd_tag  (lookup_tag),
    .rd_hit  (hit),
    .rd_data (line_data)
  );

  // Hits answer in the request cycle; reset forces both outputs low at once.
  always_comb begin
    Stall     = 1'b0;
    Read_data = 32'd0;
    if (RESET) begin
      unique case (state)
        IDLE: begin
          if (is_store || (is_load && !hit)) Stall = 1'b1;
          else if (is_load) Read_data = line_data;
        end
        FILL, WRITE: Stall = 1'b1;
        RESP: Read_data = resp_reg;
        default: Stall = 1'b0;
      endcase
    end
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state     <= IDLE;
      addr_reg  <= 32'd0;
      resp_reg  <= 32'd0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= 32'd0;
      mem_wdata <= 32'd0;
      hit_cnt   <= 16'd0;
      miss_cnt  <= 16'd0;
    end else begin
      unique case (state)
        IDLE: begin
          if (is_store) begin
            addr_reg  <= Address;
            mem_req   <= 1'b1;
            mem_we    <= 1'b1;
            mem_addr  <= {Address[31:2], 2'b00};
            mem_wdata <= Write_Data;
            state     <= WRITE;
          end else if (is_load) begin
            if (hit) begin
              hit_cnt <= hit_cnt + 16'd1;
            end else begin
              miss_cnt <= miss_cnt + 16'd1;
              addr_reg <= Address;
              mem_req  <= 1'b1;
              mem_we   <= 1'b0;
              mem_addr <= {Address[31:2], 2'b00};
              state    <= FILL;
            end
          end
        end
        FILL: begin
          if (mem_ack) begin
            mem_req  <= 1'b0;
            resp_reg <= mem_rdata;
            state    <= RESP;
          end
        end
        WRITE: begin
          if (mem_ack) begin
            mem_req <= 1'b0;
            mem_we  <= 1'b0;
            state   <= RESP;
          end
        end
        RESP:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_data_cache_ctrl.sv
// Randomized self-checking bench for data_cache_ctrl against a line-level cache model.
module tb_data_cache_ctrl;

  logic        CLK = 1'b0;
  logic        RESET;
  logic        MemRead, MemWrite;
  logic [31:0] Address, Write_Data;
  logic [31:0] Read_data;
  logic        Stall;
  logic        mem_req, mem_we;
  logic [31:0] mem_addr, mem_wdata;
  logic        mem_ack;
  logic [31:0] mem_rdata;
  logic [15:0] hit_cnt, miss_cnt;

  data_cache_ctrl dut (
    .CLK       (CLK),
    .RESET     (RESET),
    .MemRead   (MemRead),
    .MemWrite  (MemWrite),
    .Address   (Address),
    .Write_Data(Write_Data),
    .Read_data (Read_data),
    .Stall     (Stall),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_ack   (mem_ack),
    .mem_rdata (mem_rdata),
    .hit_cnt   (hit_cnt),
    .miss_cnt  (miss_cnt)
  );

  always #5 CLK = ~CLK;

  int tests = 0;
  int fails = 0;

  // Per-cycle expectations consumed by the compare process.
  bit          chk_en = 1'b0;
  logic        exp_stall, exp_req, exp_we, chk_rd;
  logic [31:0] exp_rd, exp_addr, exp_wdata;
  logic [15:0] exp_hit, exp_miss;
  int          pend_hit, pend_miss;

  // Cache contents as the specification defines them, plus backing memory.
  bit          mvalid [16];
  logic [25:0] mtag   [16];
  logic [31:0] mdata  [16];
  logic [31:0] mem_model [logic [31:0]];
  logic [31:0] last_rd;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %h, required %h at %0t", name, act, req, $time);
    end
  endtask

  always @(negedge CLK) begin
    if (chk_en) begin
      check("stall", 32'(Stall), 32'(exp_stall));
      check("mem_req", 32'(mem_req), 32'(exp_req));
      if (exp_req) begin
        check("mem_we", 32'(mem_we), 32'(exp_we));
        check("mem_addr", mem_addr, exp_addr);
        if (exp_we) check("mem_wdata", mem_wdata, exp_wdata);
      end
      if (chk_rd) check("read_data", Read_data, exp_rd);
      check("hit_cnt", 32'(hit_cnt), 32'(exp_hit));
      check("miss_cnt", 32'(miss_cnt), 32'(exp_miss));
    end
  end

  function automatic logic [31:0] mem_read(input logic [31:0] waddr);
    if (!mem_model.exists(waddr)) mem_model[waddr] = $urandom;
    return mem_model[waddr];
  endfunction

  task automatic next_cycle();
    @(posedge CLK);
    #1;
    exp_hit  = exp_hit + 16'(pend_hit);
    exp_miss = exp_miss + 16'(pend_miss);
    pend_hit  = 0;
    pend_miss = 0;
  endtask

  task automatic idle();
    next_cycle();
    MemRead    = 1'b0;
    MemWrite   = 1'b0;
    Address    = $urandom;
    Write_Data = $urandom;
    mem_ack    = 1'b0;
    exp_stall  = 1'b0;
    exp_req    = 1'b0;
    chk_rd     = 1'b1;
    exp_rd     = 32'd0;
  endtask

  // One MEM-stage request; the pipeline holds it through the stall, while
  // the bench scrambles the inputs in between to show they are ignored.
  task automatic do_txn(input bit rd, input bit wr, input logic [31:0] addr,
                        input logic [31:0] wdata, input int lat);
    int          idx;
    logic [25:0] tg;
    logic [31:0] waddr;
    logic [31:0] rval;
    bit          hit;
    idx   = int'(addr[5:2]);
    tg    = addr[31:6];
    waddr = {addr[31:2], 2'b00};
    hit   = mvalid[idx] && (mtag[idx] == tg);
    next_cycle();
    MemRead = rd; MemWrite = wr; Address = addr; Write_Data = wdata; mem_ack = 1'b0;
    exp_req = 1'b0;
    if (rd && !wr && hit) begin
      exp_stall = 1'b0; chk_rd = 1'b1; exp_rd = mdata[idx]; pend_hit = 1;
      @(negedge CLK);
      last_rd = Read_data;
      $display("[TB] load  addr=%h hit  data=%h", addr, last_rd);
      return;
    end
    exp_stall = 1'b1; chk_rd = 1'b0;
    if (!wr) pend_miss = 1;
    rval = wr ? 32'd0 : mem_read(waddr);
    for (int k = 1; k <= lat; k++) begin
      next_cycle();
      MemRead    = 1'($urandom_range(0, 1));
      MemWrite   = 1'($urandom_range(0, 1));
      Address    = $urandom;
      Write_Data = $urandom;
      exp_req = 1'b1; exp_we = wr; exp_addr = waddr; exp_wdata = wdata;
      mem_ack   = (k == lat);
      mem_rdata = wr ? $urandom : rval;
    end
    next_cycle();
    MemRead = rd; MemWrite = wr; Address = addr; Write_Data = wdata;
    mem_ack = 1'b0; mem_rdata = $urandom;
    exp_stall = 1'b0; exp_req = 1'b0;
    if (wr) begin
      chk_rd = 1'b0;
      mem_model[waddr] = wdata;
      if (hit) mdata[idx] = wdata;
    end else begin
      chk_rd = 1'b1; exp_rd = rval;
      mvalid[idx] = 1'b1; mtag[idx] = tg; mdata[idx] = rval;
    end
    @(negedge CLK);
    last_rd = Read_data;
    if (wr) $display("[TB] store addr=%h %s data=%h lat=%0d", addr, hit ? "hit " : "miss", wdata, lat);
    else    $display("[TB] load  addr=%h miss data=%h lat=%0d", addr, last_rd, lat);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL timeout: simulation did not finish, required completion");
    $fatal(1, "timeout");
  end

  initial begin
    int r;
    logic [31:0] a;
    RESET = 1'b0; MemRead = 1'b0; MemWrite = 1'b0; Address = '0; Write_Data = '0;
    mem_ack = 1'b0; mem_rdata = '0;
    exp_hit = '0; exp_miss = '0; pend_hit = 0; pend_miss = 0;
    exp_stall = 1'b0; exp_req = 1'b0; exp_we = 1'b0; chk_rd = 1'b1; exp_rd = '0;
    exp_addr = '0; exp_wdata = '0;
    for (int i = 0; i < 16; i++) mvalid[i] = 1'b0;
    mem_model[32'h40] = 32'hDEADBEEF;

    repeat (2) @(posedge CLK);
    @(negedge CLK);
    check("rst_stall", 32'(Stall), 32'd0);
    check("rst_rdata", Read_data, 32'd0);
    check("rst_req", 32'(mem_req), 32'd0);
    check("rst_addr", mem_addr, 32'd0);
    check("rst_cnt", {hit_cnt, miss_cnt}, 32'd0);
    @(posedge CLK); #1;
    RESET = 1'b1;
    chk_en = 1'b1;

    // Directed scenarios with hand-computed results.
    do_txn(1, 0, 32'h40, 32'd0, 3);
    check("cold_load_data", last_rd, 32'hDEADBEEF);
    do_txn(1, 0, 32'h40, 32'd0, 1);
    check("hit_load_data", last_rd, 32'hDEADBEEF);
    idle(); @(negedge CLK);
    check("cnt_after_hit", {hit_cnt, miss_cnt}, 32'h0001_0001);
    do_txn(0, 1, 32'h40, 32'h12345678, 2);
    do_txn(1, 0, 32'h40, 32'd0, 1);
    check("store_hit_update", last_rd, 32'h12345678);
    do_txn(0, 1, 32'h80, 32'hCAFEF00D, 4);
    do_txn(1, 0, 32'h40, 32'd0, 1);
    check("no_allocate", last_rd, 32'h12345678);
    do_txn(1, 0, 32'h80, 32'd0, 2);
    check("store_reached_mem", last_rd, 32'hCAFEF00D);
    do_txn(1, 0, 32'h40, 32'd0, 1);
    do_txn(1, 0, 32'h440, 32'd0, 2);
    do_txn(1, 0, 32'h40, 32'd0, 3);
    check("conflict_refill", last_rd, 32'h12345678);
    idle(); @(negedge CLK);
    check("cnt_after_conflict", {hit_cnt, miss_cnt}, 32'h0003_0005);

    // Reset in the middle of a fill, then a stray late mem_ack.
    chk_en = 1'b0;
    next_cycle(); MemRead = 1'b1; MemWrite = 1'b0; Address = 32'h440; mem_ack = 1'b0;
    next_cycle();
    next_cycle();
    RESET = 1'b0;
    #1;
    check("midfill_rst_req", 32'(mem_req), 32'd0);
    check("midfill_rst_stall", 32'(Stall), 32'd0);
    check("midfill_rst_rdata", Read_data, 32'd0);
    check("midfill_rst_bus", {mem_addr[15:0], 15'd0, mem_we}, 32'd0);
    check("midfill_rst_wdata", mem_wdata, 32'd0);
    check("midfill_rst_cnt", {hit_cnt, miss_cnt}, 32'd0);
    next_cycle(); RESET = 1'b1; MemRead = 1'b0;
    for (int i = 0; i < 16; i++) mvalid[i] = 1'b0;
    exp_hit = '0; exp_miss = '0;
    next_cycle(); mem_ack = 1'b1; mem_rdata = 32'hBAD0BAD0;
    @(negedge CLK);
    check("late_ack_ignored", {15'd0, Stall, 15'd0, mem_req}, 32'd0);
    idle();
    chk_en = 1'b1;
    do_txn(1, 0, 32'h40, 32'd0, 2);
    check("after_rst_refill", last_rd, 32'h12345678);
    idle(); @(negedge CLK);
    check("cnt_after_rst", {hit_cnt, miss_cnt}, 32'h0000_0001);

    // Randomized traffic over a small address pool to mix hits and conflicts.
    for (int n = 0; n < 300; n++) begin
      r = $urandom_range(0, 9);
      a = (32'($urandom_range(0, 3)) << 6) | (32'($urandom_range(0, 15)) << 2)
          | 32'($urandom_range(0, 3));
      if ($urandom_range(0, 3) == 0) a = a | 32'h8000_0000;
      if (r < 5)       do_txn(1, 0, a, $urandom, $urandom_range(1, 4));
      else if (r < 8)  do_txn(0, 1, a, $urandom, $urandom_range(1, 4));
      else if (r == 8) do_txn(1, 1, a, $urandom, $urandom_range(1, 4));
      else             idle();
    end
    idle();
    @(negedge CLK);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/data_cache_ctrl.md
Name: data_cache_ctrl

Overview:
Memory-side responder for the MEM-stage load/store requests (MemRead/MemWrite, Address, Write_Data). It is a direct-mapped, one-word-per-line, write-through, no-write-allocate data cache in front of a multi-cycle backing memory reached over a req/ack handshake. It returns Read_data and raises Stall to freeze the pipeline on a miss or on any store. It replaces the single-cycle data memory between the EX/MEM and MEM/WB registers.

Parameters:
LINES, 16, number of cache lines; power of two, minimum 2.
IDX_W, log2(LINES) = 4, index width; index = Address[IDX_W+1:2].
TAG_W, 30-IDX_W = 26, tag width; tag = Address[31:IDX_W+2].

Ports:
CLK  in  1  clock, rising edge.
RESET  in  1  asynchronous active-low reset.
MemRead  in  1  load request from MEM stage.
MemWrite  in  1  store request from MEM stage.
Address  in  32  byte address; bits [1:0] ignored.
Write_Data  in  32  store data.
Read_data  out  32  load data to MEM/WB.
Stall  out  1  hold PC, IF/ID, ID/EX, EX/MEM; bubble MEM/WB.
mem_req  out  1  backing-memory request, held until mem_ack.
mem_we  out  1  1 = write, 0 = read; valid while mem_req.
mem_addr  out  32  word-aligned address {addr[31:2], 2'b00}.
mem_wdata  out  32  write data.
mem_ack  in  1  one-cycle completion pulse from backing memory.
mem_rdata  in  32  read data; valid with mem_ack on reads.
hit_cnt  out  16  load hits, wraps at 16'hFFFF->0.
miss_cnt  out  16  load misses, wraps.

Behaviour:
- Reset (RESET=0, async): all valid bits 0, state IDLE, mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0, Read_data=0, Stall=0, hit_cnt=0, miss_cnt=0. Tag/data arrays need not be cleared. Reset mid-transaction abandons it; a late mem_ack is ignored.
- States: IDLE, FILL, WRITE, RESP.
- IDLE, no request: Stall=0, Read_data=0.
- IDLE, MemRead hit (valid[idx] and tag match): Read_data=data[idx] combinationally, Stall=0, zero latency; hit_cnt+1.
- IDLE, MemRead miss: Stall=1 combinationally. Latch addr. Next state FILL. miss_cnt+1.
- IDLE, MemWrite (hit or miss): Stall=1. Latch addr and Write_Data. Next state WRITE.
- MemRead and MemWrite both high: treat as a write.
- FILL: mem_req=1, mem_we=0, Stall=1. On mem_ack: data[idx]<=mem_rdata, tag[idx]<=tag, valid[idx]<=1, resp_reg<=mem_rdata, next state RESP.
- WRITE: mem_req=1, mem_we=1, mem_wdata=latched data, Stall=1. On mem_ack: if the line hits, update data[idx] (no allocate on miss), next state RESP.
- RESP: Stall=0 and Read_data=resp_reg (don't-care for stores). The request on the bus this cycle is the completed one and is not re-issued or re-counted. Next state is always IDLE.
- mem_req deasserts in the cycle after mem_ack. mem_addr, mem_we and mem_wdata stay stable while mem_req=1.
- mem_ack outside FILL/WRITE is ignored. Input changes during FILL/WRITE are ignored; latched values are used.
- Load miss latency: Stall high for 1 + N cycles, where N = cycles from mem_req rise to mem_ack inclusive; data is returned in RESP. A store takes the same timing.

Decomposition:
- Shared package dcache_pkg: state enum (IDLE, FILL, WRITE, RESP), LINES/IDX_W/TAG_W defaults, helper functions for idx/tag extraction.
- Sub-module dcache_array: valid/tag/data storage.
  - One write port with write-enable, index, tag, data and set-valid.
  - One combinational read port giving hit and data.
  - Async active-low clear of valid bits only.

Test Plan:
- Cold load of 0x0000_0040, mem_ack 3 cycles after mem_req -> Stall high 4 cycles. mem_addr=0x40, mem_we=0. RESP cycle gives Read_data=mem_rdata=0xDEADBEEF, Stall=0. miss_cnt=1.
- Repeat load of 0x40 -> Read_data=0xDEADBEEF the same cycle, Stall=0, no mem_req, hit_cnt=1.
- Store 0x1234_5678 to 0x40 (hit) -> mem_req with mem_we=1, mem_wdata=0x12345678. Then load 0x40 hits with 0x12345678.
- Store to 0x80 (miss, same index as 0x40 when LINES=16) -> memory is written, no allocate. Load 0x40 still hits with the old line. Load 0x80 misses.
- Conflict: load 0x40, then load 0x440 -> both miss. A subsequent load of 0x40 misses again. miss_cnt=3.
- Assert RESET during FILL before mem_ack -> mem_req=0 and all outputs are zero immediately. A later mem_ack pulse causes no fill, and load 0x40 then misses.
